// File: rtl/hazard_sb.sv
// hazard_sb: pipeline hazard scoreboard (forwarding, load-use/MD stalls, control flushes).
// Optional perf counters under HAZARD_PERF_EN.
module hazard_sb #(
  parameter int AW = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_D,
  input  logic [AW-1:0] rs2_D,
  input  logic [AW-1:0] rd_D,
  input  logic [AW-1:0] rs1_E,
  input  logic [AW-1:0] rs2_E,
  input  logic [AW-1:0] rd_E,
  input  logic [AW-1:0] rd_M,
  input  logic [AW-1:0] rd_W,
  input  logic          regwrite_D,
  input  logic          regwrite_E,
  input  logic          regwrite_M,
  input  logic          regwrite_W,
  input  logic          memtoreg_E,
  input  logic          md_op_D,
  input  logic          md_start_E,
  input  logic          jump_E,
  input  logic          branch_E,
  input  logic          predict_en_E,
  input  logic          branch_h_E,
  output logic [1:0]    forwardA_E,
  output logic [1:0]    forwardB_E,
  output logic          stall_F,
  output logic          stall_D,
  output logic          flush_F_to_D,
  output logic          flush_D_to_E,
  output logic          md_busy,
  output logic          md_done,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
);
  localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);
  localparam logic [4:0] MD_INIT = 5'(MD_LAT - 1);
  logic [1:0]    r_ld_cnt;
  logic [4:0]    r_md_cnt;
  logic          r_md_busy, r_md_done, r_pend_v;
  logic [AW-1:0] r_pend_rd;
  logic          w_busy, w_done, w_pend, w_ld_act, w_lu, w_raw, w_waw, w_str, w_ctrl, w_stall;
  // State is masked during reset so outputs reflect the cleared state immediately.
  assign w_busy   = r_md_busy && !rst;
  assign w_done   = r_md_done && !rst;
  assign w_pend   = r_pend_v && !rst;
  assign w_ld_act = (r_ld_cnt != 2'd0) && !rst;
  assign w_lu     = memtoreg_E && (rd_E != '0) && (rd_E == rs1_D || rd_E == rs2_D);
  assign w_raw    = w_pend && ((rs1_D != '0 && rs1_D == r_pend_rd) || (rs2_D != '0 && rs2_D == r_pend_rd));
  assign w_waw    = w_pend && regwrite_D && (rd_D == r_pend_rd);
  assign w_str    = md_op_D && (w_busy || w_done);
  assign w_ctrl   = jump_E || (branch_E && (predict_en_E != branch_h_E));
  assign w_stall  = w_lu || w_ld_act || w_raw || w_waw || w_str;
  always_comb begin
    forwardA_E   = (rs1_E != '0 && regwrite_M && rd_M == rs1_E) ? 2'b10 :
                   (rs1_E != '0 && regwrite_W && rd_W == rs1_E) ? 2'b01 : 2'b00;
    forwardB_E   = (rs2_E != '0 && regwrite_M && rd_M == rs2_E) ? 2'b10 :
                   (rs2_E != '0 && regwrite_W && rd_W == rs2_E) ? 2'b01 : 2'b00;
    stall_F      = w_stall && !w_ctrl;
    stall_D      = w_stall && !w_ctrl;
    flush_F_to_D = w_ctrl;
    flush_D_to_E = w_ctrl || w_stall;
    md_busy      = w_busy;
    md_done      = w_done;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_cnt  <= '0;
      r_md_cnt  <= '0;
      r_md_busy <= 1'b0;
      r_md_done <= 1'b0;
      r_pend_v  <= 1'b0;
      r_pend_rd <= '0;
    end else begin
      r_ld_cnt <= w_ctrl ? 2'd0 : (r_ld_cnt != 2'd0) ? r_ld_cnt - 2'd1 : w_lu ? LD_INIT : 2'd0;
      if (r_md_busy) begin
        if (r_md_cnt != 5'd0) r_md_cnt <= r_md_cnt - 5'd1;
        r_md_done <= (r_md_cnt == 5'd1);
        if (r_md_done) begin
          r_md_busy <= 1'b0;
          r_pend_v  <= 1'b0;
        end
      end else if (md_start_E) begin
        r_md_busy <= 1'b1;
        r_md_cnt  <= MD_INIT;
        r_pend_v  <= (rd_E != '0);
        r_pend_rd <= rd_E;
      end
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, stall_D};
      r_flush_cnt <= r_flush_cnt + {31'd0, w_ctrl};
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: directed and random checks of hazard_sb against a cycle-indexed reference model.
module tb_hazard_sb;
  localparam int AW = 5, LL = 2, ML = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic regwrite_D, regwrite_E, regwrite_M, regwrite_W, memtoreg_E, md_op_D, md_start_E;
  logic jump_E, branch_E, predict_en_E, branch_h_E;
  logic [1:0] forwardA_E, forwardB_E;
  logic stall_F, stall_D, flush_F_to_D, flush_D_to_E, md_busy, md_done;
  logic [31:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0;
  int cyc = 0, ms = -1, prd = 0, ld_end = -1, scnt = 0, fcnt = 0;
  logic e_stall, e_ctrl, e_busy, e_lu, e_ldact;

  hazard_sb #(.AW(AW), .LOAD_LAT(LL), .MD_LAT(ML)) dut (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .regwrite_D(regwrite_D), .regwrite_E(regwrite_E),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .memtoreg_E(memtoreg_E), .md_op_D(md_op_D),
    .md_start_E(md_start_E), .jump_E(jump_E), .branch_E(branch_E), .predict_en_E(predict_en_E),
    .branch_h_E(branch_h_E), .forwardA_E(forwardA_E), .forwardB_E(forwardB_E), .stall_F(stall_F),
    .stall_D(stall_D), .flush_F_to_D(flush_F_to_D), .flush_D_to_E(flush_D_to_E), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (rs != 0 && regwrite_M && rd_M == rs) return 2'b10;
    if (rs != 0 && regwrite_W && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    {rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    {regwrite_D, regwrite_E, regwrite_M, regwrite_W, memtoreg_E, md_op_D, md_start_E} = '0;
    {jump_E, branch_E, predict_en_E, branch_h_E} = '0;
  endtask

  // Evaluate the model for the current cycle at the negative edge and compare every output.
  task automatic settle();
    logic pend, raw, waw, str, done;
    logic [31:0] es, ef;
    @(negedge clk);
    e_busy  = !rst && ms >= 0 && cyc > ms && cyc <= ms + ML;
    done    = !rst && ms >= 0 && cyc == ms + ML;
    pend    = e_busy && prd != 0;
    e_ldact = !rst && cyc <= ld_end;
    e_lu    = memtoreg_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    raw     = pend && ((rs1_D != 0 && int'(rs1_D) == prd) || (rs2_D != 0 && int'(rs2_D) == prd));
    waw     = pend && regwrite_D && int'(rd_D) == prd;
    str     = md_op_D && e_busy;
    e_ctrl  = jump_E || (branch_E && predict_en_E != branch_h_E);
    e_stall = (e_lu || e_ldact || raw || waw || str) && !e_ctrl;
`ifdef HAZARD_PERF_EN
    es = scnt; ef = fcnt;
`else
    es = 0; ef = 0;
`endif
    chk("fwdA", 32'(forwardA_E), 32'(fwd(rs1_E)));
    chk("fwdB", 32'(forwardB_E), 32'(fwd(rs2_E)));
    chk("stall_F", 32'(stall_F), 32'(e_stall));
    chk("stall_D", 32'(stall_D), 32'(e_stall));
    chk("flush_FD", 32'(flush_F_to_D), 32'(e_ctrl));
    chk("flush_DE", 32'(flush_D_to_E), 32'(e_ctrl || e_stall));
    chk("md_busy", 32'(md_busy), 32'(e_busy));
    chk("md_done", 32'(md_done), 32'(done));
    chk("stall_cnt", stall_cnt, es);
    chk("flush_cnt", flush_cnt, ef);
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      ms = -1; ld_end = -1; scnt = 0; fcnt = 0;
    end else begin
      if (e_ctrl) ld_end = -1;
      else if (!e_ldact && e_lu) ld_end = cyc + LL - 1;
      if (!e_busy && md_start_E) begin ms = cyc; prd = int'(rd_E); end
      scnt += int'(e_stall);
      fcnt += int'(e_ctrl);
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle(); chk("rst_busy", 32'(md_busy), 0); chk("rst_stall", 32'(stall_D), 0); adv();
    // x0 never creates hazards or forwarding
    memtoreg_E = 1; rd_E = 0; rs2_D = 0; rs1_E = 0; rd_M = 0; regwrite_M = 1;
    settle(); chk("x0_stall", 32'(stall_D), 0); chk("x0_fwd", 32'(forwardA_E), 0); adv();
    clr();
    rs1_E = 7; rd_M = 7; rd_W = 7; regwrite_M = 1; regwrite_W = 1;
    settle(); chk("prio_M", 32'(forwardA_E), 32'b10); adv();
    regwrite_M = 0;
    settle(); chk("prio_W", 32'(forwardA_E), 32'b01); adv();
    clr();
    // load-use lasts LOAD_LAT cycles
    memtoreg_E = 1; rd_E = 5; rs1_D = 5;
    settle(); chk("lu_c0", 32'(stall_D), 1); chk("lu_c0_fl", 32'(flush_D_to_E), 1); adv();
    memtoreg_E = 0;
    settle(); chk("lu_c1", 32'(stall_D), 1); chk("lu_c1_fl", 32'(flush_D_to_E), 1); adv();
    settle(); chk("lu_c2", 32'(stall_D), 0); adv();
    // jump during an active load stall
    memtoreg_E = 1;
    step();
    memtoreg_E = 0; jump_E = 1;
    settle(); chk("jf_fd", 32'(flush_F_to_D), 1); chk("jf_de", 32'(flush_D_to_E), 1);
    chk("jf_stF", 32'(stall_F), 0); adv();
    jump_E = 0;
    settle(); chk("jf_cleared", 32'(stall_D), 0); adv();
    clr();
    // MD RAW: stall held until the cycle after md_done
    md_start_E = 1; rd_E = 9;
    step();
    md_start_E = 0; rs2_D = 9;
    for (int k = 1; k <= ML; k++) begin
      settle(); chk("md_raw_stall", 32'(stall_D), 1); chk("md_done_t", 32'(md_done), 32'(k == ML)); adv();
    end
    settle(); chk("md_rel", 32'(stall_D), 0); chk("md_idle", 32'(md_busy), 0); adv();
    clr();
    // reset in the middle of an MD op
    md_start_E = 1; rd_E = 9;
    step();
    md_start_E = 0;
    step();
    step();
    rst = 1;
    step();
    rst = 0; rs2_D = 9;
    for (int k = 0; k < ML + 2; k++) begin
      settle(); chk("mr_done", 32'(md_done), 0); chk("mr_busy", 32'(md_busy), 0);
      chk("mr_stall", 32'(stall_D), 0); adv();
    end
    clr();
    for (int n = 0; n < 400; n++) begin
      rs1_D = AW'($urandom_range(0, 3)); rs2_D = AW'($urandom_range(0, 3)); rd_D = AW'($urandom_range(0, 3));
      rs1_E = AW'($urandom_range(0, 3)); rs2_E = AW'($urandom_range(0, 3)); rd_E = AW'($urandom_range(0, 3));
      rd_M = AW'($urandom_range(0, 3)); rd_W = AW'($urandom_range(0, 3));
      regwrite_D = 1'($urandom); regwrite_E = 1'($urandom); regwrite_M = 1'($urandom); regwrite_W = 1'($urandom);
      memtoreg_E = ($urandom_range(0, 3) == 0); md_op_D = ($urandom_range(0, 3) == 0);
      md_start_E = ($urandom_range(0, 7) == 0); jump_E = ($urandom_range(0, 15) == 0);
      branch_E = ($urandom_range(0, 3) == 0); predict_en_E = 1'($urandom); branch_h_E = 1'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width (2^AW architectural registers, x0 hardwired zero).
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (legal 1..3).
REQ-003 SHALL have parameter MD_LAT, default 4, multi-cycle mul/div latency in cycles (legal 2..32).
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have inputs: rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W, each AW bits, stage register addresses.
REQ-006 SHALL have inputs, 1 bit each: regwrite_D, regwrite_E, regwrite_M, regwrite_W, memtoreg_E, md_op_D, md_start_E.
REQ-007 SHALL have inputs, 1 bit each: jump_E, branch_E, predict_en_E, branch_h_E (predicted taken; actual taken).
REQ-008 SHALL have outputs: forwardA_E, forwardB_E, 2 bits each (10 = from M, 01 = from W, 00 = regfile).
REQ-009 SHALL have outputs, 1 bit each: stall_F, stall_D, flush_F_to_D, flush_D_to_E, md_busy, md_done.
REQ-010 SHALL have outputs stall_cnt and flush_cnt, 32 bits each, performance counters.

Function
REQ-011 Forwarding SHALL be combinational: M match beats W match; a match needs a nonzero rs, equal rd and the stage regwrite set.
REQ-012 A load-use hazard SHALL be memtoreg_E, rd_E != 0, and rd_E equal to rs1_D or rs2_D.
REQ-013 A load-use hazard SHALL assert stall_F, stall_D and flush_D_to_E in the same cycle and load a counter with LOAD_LAT-1.
REQ-014 While the load counter is nonzero, the block SHALL hold stall_F, stall_D and flush_D_to_E, decrementing once per cycle; total stall = LOAD_LAT cycles.
REQ-015 md_start_E with md_busy low SHALL set a pending bit for rd_E (ignored when rd_E = 0), load an MD counter with MD_LAT-1 and set md_busy on the next cycle.
REQ-016 The MD counter SHALL decrement while busy; at 0, md_done SHALL pulse 1 cycle, the pending bit SHALL clear, and md_busy SHALL drop on the following cycle.
REQ-017 A RAW hazard SHALL stall F/D and flush D->E when rs1_D or rs2_D (nonzero) equals the pending rd.
REQ-018 A WAW hazard SHALL stall when regwrite_D is set and rd_D equals the pending rd.
REQ-019 A structural hazard SHALL stall when md_op_D is set and md_busy is high, or when md_done is high in the same cycle.
REQ-020 Mispredict SHALL be branch_E with predict_en_E != branch_h_E; mispredict or jump_E SHALL assert flush_F_to_D and flush_D_to_E.
REQ-021 Mispredict or jump_E SHALL deassert stall_F and stall_D and clear the load counter; a control flush beats any stall.
REQ-022 An in-flight MD operation SHALL NOT be cancelled by a flush.
REQ-023 md_start_E while busy SHALL be ignored; an upstream structural stall prevents this case.

Reset
REQ-024 rst SHALL clear the pending bit, both counters, md_busy, md_done, stall_cnt and flush_cnt to 0 on the next clk edge, including mid-operation.
REQ-025 Combinational outputs SHALL depend only on inputs and cleared state during and after reset.

Configuration
REQ-026 With macro HAZARD_PERF_EN defined, stall_cnt SHALL increment on each stall_D cycle and flush_cnt on each control flush, both wrapping at 2^32.
REQ-027 Without HAZARD_PERF_EN, stall_cnt and flush_cnt SHALL be tied to 0 and the counters omitted.

Verification
REQ-028 Load-use test: memtoreg_E=1, rd_E=5, rs1_D=5, LOAD_LAT=2 -> stall_D and flush_D_to_E high for exactly 2 cycles.
REQ-029 x0 test: memtoreg_E=1, rd_E=0, rs2_D=0 -> no stall; rs1_E=0 with rd_M=0 -> forwardA_E=00.
REQ-030 Priority test: rs1_E=rd_M=rd_W=7, both regwrite set -> forwardA_E=10; clear regwrite_M -> 01.
REQ-031 MD RAW test: MD_LAT=4, md_start_E, rd_E=9, then rs2_D=9 -> stall held; md_done pulses 4 cycles after start; stall released the cycle after md_done.
REQ-032 Flush-over-stall test: jump_E=1 during an active load stall -> both flushes high, stall_F=0, load counter cleared; flush_cnt +1 with HAZARD_PERF_EN.
REQ-033 Mid-reset test: rst asserted 2 cycles into an MD operation -> md_busy=0, pending bit cleared, no md_done pulse afterward.
